if_stage: RTL and testbench

Instruction Fetch stage of the pipelined MIPS core: owns the PC register and the instruction memory, and produces the IF/ID pipeline register (instruction, PC+4) consumed by the decode stage. It also serves the PC-redirect requests from decode: branch taken with target, jump-register with rs data, and J/JAL with instruction index. The debug unit loads the program through a write port and steps the pipeline through a clock-enable.

---
 rtl/mips_pkg.sv | 17 +
 rtl/if_stage_if.sv | 34 +++
 rtl/instruction_mem.sv | 28 ++
 rtl/if_stage.sv | 87 ++++++++
 tb/tb_if_stage.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipeline front end.
package mips_pkg;

    localparam int unsigned NB_REG       = 32;
    localparam int unsigned NB_IMEM_ADDR = 8;
    localparam int unsigned NB_INDEX     = 26;

    localparam logic [NB_REG-1:0] NOP_INST  = 32'h0000_0000;
    localparam logic [NB_REG-1:0] HALT_INST = 32'hFFFF_FFFF;
    localparam logic [NB_REG-1:0] PC_RESET  = 32'h0000_0000;

    // Clear the byte-offset bits so redirect targets are always word aligned.
    function automatic logic [NB_REG-1:0] word_align(input logic [NB_REG-1:0] addr);
        return addr & ~NB_REG'(3);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: redirect/stall inputs from decode and hazard logic,
// debug-unit load/step controls, and the IF/ID outputs.
interface if_stage_if;
    import mips_pkg::*;

    logic                    i_dunit_clk_en;
    logic                    i_stall;
    logic                    i_PCSrc;
    logic [NB_REG-1:0]       i_branch_target;
    logic                    i_jr;
    logic [NB_REG-1:0]       i_pc_jsel;
    logic                    i_jump;
    logic [NB_INDEX-1:0]     i_instr_index;
    logic                    i_dunit_we;
    logic [NB_IMEM_ADDR-1:0] i_dunit_waddr;
    logic [NB_REG-1:0]       i_dunit_wdata;
    logic [NB_REG-1:0]       o_inst;
    logic [NB_REG-1:0]       o_pcplus4;
    logic [NB_REG-1:0]       o_pc;
    logic                    o_halt;

    modport master (
        output i_dunit_clk_en, i_stall, i_PCSrc, i_branch_target, i_jr, i_pc_jsel,
               i_jump, i_instr_index, i_dunit_we, i_dunit_waddr, i_dunit_wdata,
        input  o_inst, o_pcplus4, o_pc, o_halt
    );

    modport slave (
        input  i_dunit_clk_en, i_stall, i_PCSrc, i_branch_target, i_jr, i_pc_jsel,
               i_jump, i_instr_index, i_dunit_we, i_dunit_waddr, i_dunit_wdata,
        output o_inst, o_pcplus4, o_pc, o_halt
    );

endinterface

// File: rtl/instruction_mem.sv
// Instruction memory: one synchronous write port, one asynchronous read port,
// contents are not reset.
module instruction_mem #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [NB_DATA-1:0] wdata,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [NB_DATA-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] mem [DEPTH];

    // Write port; a read of the same word in this cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, instruction memory and IF/ID register.
// Optional build macro IF_BRANCH_FLUSH_EN replaces the delay-slot instruction
// with a NOP whenever a redirect is taken.
module if_stage
    import mips_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    if_stage_if.slave  bus
);

    logic [NB_REG-1:0] pc;
    logic [NB_REG-1:0] inst;
    logic [NB_REG-1:0] pcplus4;
    logic              halt;

    logic [NB_REG-1:0] fetch_word;
    logic [NB_REG-1:0] pc_seq;
    logic [NB_REG-1:0] pc_next;
    logic [NB_REG-1:0] inst_next;
    logic [NB_REG-1:0] pcplus4_next;
    logic              advance;
    logic              halt_hit;
`ifdef IF_BRANCH_FLUSH_EN
    logic              redirect;
`endif

    instruction_mem #(
        .NB_DATA (NB_REG),
        .NB_ADDR (NB_IMEM_ADDR)
    ) u_imem (
        .clk   (i_clk),
        .we    (bus.i_dunit_we),
        .waddr (bus.i_dunit_waddr),
        .wdata (bus.i_dunit_wdata),
        .raddr (pc[NB_IMEM_ADDR+1:2]),
        .rdata (fetch_word)
    );

    // Advance qualification, next-PC priority mux and IF/ID capture values.
    always_comb begin
        advance = bus.i_dunit_clk_en & ~bus.i_stall & ~halt;
        pc_seq  = pc + NB_REG'(4);
        pc_next = pc_seq;
        if (bus.i_jr) begin
            pc_next = word_align(bus.i_pc_jsel);
        end else if (bus.i_jump) begin
            pc_next = {pcplus4[NB_REG-1:NB_REG-4], bus.i_instr_index, 2'b00};
        end else if (bus.i_PCSrc) begin
            pc_next = word_align(bus.i_branch_target);
        end
`ifdef IF_BRANCH_FLUSH_EN
        redirect     = bus.i_jr | bus.i_jump | bus.i_PCSrc;
        inst_next    = redirect ? NOP_INST : fetch_word;
        pcplus4_next = redirect ? '0 : pc_seq;
        halt_hit     = ~redirect & (fetch_word == HALT_INST);
`else
        inst_next    = fetch_word;
        pcplus4_next = pc_seq;
        halt_hit     = (fetch_word == HALT_INST);
`endif
    end

    // PC / IF/ID / halt registers; a fetched halt freezes the PC on its own address.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            pc      <= PC_RESET;
            inst    <= NOP_INST;
            pcplus4 <= '0;
            halt    <= 1'b0;
        end else if (advance) begin
            inst    <= inst_next;
            pcplus4 <= pcplus4_next;
            if (halt_hit) begin
                halt <= 1'b1;
            end else begin
                pc <= pc_next;
            end
        end
    end

    assign bus.o_pc      = pc;
    assign bus.o_inst    = inst;
    assign bus.o_pcplus4 = pcplus4;
    assign bus.o_halt    = halt;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle model feeds a scoreboard queue, plus directed checks.
module tb_if_stage;
    import mips_pkg::*;

`ifdef IF_BRANCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_stage_if bus ();

    if_stage dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pcp4;
        logic        halt;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] m_mem [256];
    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_inst = 32'h0;
    logic [31:0] m_pcp4 = 32'h0;
    logic        m_halt = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.i_dunit_clk_en  = 1'b0;
        bus.i_stall         = 1'b0;
        bus.i_PCSrc         = 1'b0;
        bus.i_branch_target = 32'h0;
        bus.i_jr            = 1'b0;
        bus.i_pc_jsel       = 32'h0;
        bus.i_jump          = 1'b0;
        bus.i_instr_index   = 26'h0;
        bus.i_dunit_we      = 1'b0;
        bus.i_dunit_waddr   = 8'h0;
        bus.i_dunit_wdata   = 32'h0;
    endtask

    // Reference behaviour for one clock edge given the inputs currently driven.
    task automatic model_push();
        logic [31:0] word;
        logic [31:0] seq;
        logic [31:0] tgt;
        logic        go;
        logic        redir;
        logic        hit;
        exp_t        e;
        word  = m_mem[m_pc[9:2]];
        seq   = m_pc + 32'd4;
        go    = bus.i_dunit_clk_en && !bus.i_stall && !m_halt;
        redir = bus.i_jr || bus.i_jump || bus.i_PCSrc;
        if (bus.i_jr)         tgt = {bus.i_pc_jsel[31:2], 2'b00};
        else if (bus.i_jump)  tgt = {m_pcp4[31:28], bus.i_instr_index, 2'b00};
        else if (bus.i_PCSrc) tgt = {bus.i_branch_target[31:2], 2'b00};
        else                  tgt = seq;
        if (!rst_n) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pcp4 = 32'h0; m_halt = 1'b0;
        end else if (go) begin
            if (FLUSH && redir) begin
                m_inst = 32'h0; m_pcp4 = 32'h0; hit = 1'b0;
            end else begin
                m_inst = word; m_pcp4 = seq; hit = (word == 32'hFFFF_FFFF);
            end
            if (hit) m_halt = 1'b1;
            else     m_pc   = tgt;
        end
        if (bus.i_dunit_we) m_mem[bus.i_dunit_waddr] = bus.i_dunit_wdata;
        e.pc = m_pc; e.inst = m_inst; e.pcp4 = m_pcp4; e.halt = m_halt;
        sb_q.push_back(e);
    endtask

    // One clock: predict, wait for the edge, compare against the scoreboard head.
    task automatic step();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_pc",   bus.o_pc,        e.pc);
            check("sb_inst", bus.o_inst,      e.inst);
            check("sb_pcp4", bus.o_pcplus4,   e.pcp4);
            check("sb_halt", 32'(bus.o_halt), 32'(e.halt));
        end
    endtask

    initial begin
        clear_inputs();
        #2;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check("rst_pc",   bus.o_pc,        32'h0);
        check("rst_inst", bus.o_inst,      32'h0);
        check("rst_pcp4", bus.o_pcplus4,   32'h0);
        check("rst_halt", 32'(bus.o_halt), 32'h0);
        rst_n = 1'b1;

        // Program load with the pipeline held
        for (int i = 0; i < 256; i++) begin
            bus.i_dunit_we    = 1'b1;
            bus.i_dunit_waddr = 8'(i);
            bus.i_dunit_wdata = (i < 3) ? 32'h1111_1111 * 32'(i + 1) : (32'hA500_0000 | 32'(i));
            step();
        end
        bus.i_dunit_we = 1'b0;
        check("load_hold_pc", bus.o_pc, 32'h0);

        // Sequential fetch, stall at pc=8, release
        bus.i_dunit_clk_en = 1'b1;
        step();
        check("seq_inst0", bus.o_inst,    32'h1111_1111);
        check("seq_pcp40", bus.o_pcplus4, 32'h4);
        step();
        check("seq_inst1", bus.o_inst,    32'h2222_2222);
        check("seq_pc1",   bus.o_pc,      32'h8);
        bus.i_stall = 1'b1;
        step();
        step();
        check("stall_pc",   bus.o_pc,      32'h8);
        check("stall_inst", bus.o_inst,    32'h2222_2222);
        check("stall_pcp4", bus.o_pcplus4, 32'h8);
        bus.i_stall = 1'b0;
        step();
        check("seq_inst2", bus.o_inst,    32'h3333_3333);
        check("seq_pcp42", bus.o_pcplus4, 32'hC);

        // Reset overrides a simultaneous branch
        rst_n = 1'b0;
        bus.i_PCSrc = 1'b1;
        bus.i_branch_target = 32'h40;
        step();
        check("rstbr_pc",   bus.o_pc,   32'h0);
        check("rstbr_inst", bus.o_inst, 32'h0);
        rst_n = 1'b1;
        bus.i_PCSrc = 1'b0;

        // Write to the word being fetched: old word now, new word on refetch
        bus.i_dunit_we    = 1'b1;
        bus.i_dunit_waddr = 8'h0;
        bus.i_dunit_wdata = 32'h0BAD_0000;
        step();
        check("wr_old", bus.o_inst, 32'h1111_1111);
        bus.i_dunit_we = 1'b0;
        bus.i_jr       = 1'b1;
        bus.i_pc_jsel  = 32'h0;
        step();
        check("wr_jr_pc", bus.o_pc, 32'h0);
        check("wr_slot",  bus.o_inst, FLUSH ? 32'h0 : 32'h2222_2222);
        bus.i_jr = 1'b0;
        step();
        check("wr_new", bus.o_inst, 32'h0BAD_0000);
        step();
        check("pre_br_pc", bus.o_pc, 32'h8);

        // Taken branch at pc=8
        bus.i_PCSrc = 1'b1;
        bus.i_branch_target = 32'h40;
        step();
        check("br_pc",   bus.o_pc,   32'h40);
        check("br_slot", bus.o_inst, FLUSH ? 32'h0 : 32'h3333_3333);
        bus.i_PCSrc = 1'b0;
        step();
        check("br_tgt_inst", bus.o_inst, 32'hA500_0010);

        // JR beats J, unaligned rs data; then J alone
        bus.i_jr = 1'b1;
        bus.i_jump = 1'b1;
        bus.i_pc_jsel = 32'h83;
        bus.i_instr_index = 26'h3FF_FFFF;
        step();
        check("jr_pri_pc", bus.o_pc, 32'h80);
        bus.i_jr = 1'b0;
        bus.i_instr_index = 26'h10;
        step();
        check("j_pc", bus.o_pc, 32'h40);
        bus.i_jump = 1'b0;

        // Clock-enable low holds everything even with a redirect
        bus.i_dunit_clk_en = 1'b0;
        bus.i_PCSrc = 1'b1;
        bus.i_branch_target = 32'h100;
        step();
        step();
        check("en_hold_pc", bus.o_pc, 32'h40);
        bus.i_PCSrc = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 150; n++) begin
            bus.i_dunit_clk_en  = ($urandom_range(0, 3) != 0);
            bus.i_stall         = ($urandom_range(0, 3) == 0);
            bus.i_PCSrc         = ($urandom_range(0, 3) == 0);
            bus.i_jr            = ($urandom_range(0, 7) == 0);
            bus.i_jump          = ($urandom_range(0, 7) == 0);
            bus.i_branch_target = $urandom;
            bus.i_pc_jsel       = $urandom;
            bus.i_instr_index   = 26'($urandom);
            bus.i_dunit_we      = ($urandom_range(0, 7) == 0);
            bus.i_dunit_waddr   = 8'($urandom);
            bus.i_dunit_wdata   = $urandom & 32'h7FFF_FFFF;
            step();
        end

        // Halt at word 3
        clear_inputs();
        bus.i_dunit_we    = 1'b1;
        bus.i_dunit_waddr = 8'h3;
        bus.i_dunit_wdata = 32'hFFFF_FFFF;
        step();
        bus.i_dunit_we = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.i_dunit_we    = 1'b1;
        bus.i_dunit_waddr = 8'h0;
        bus.i_dunit_wdata = 32'h0BAD_0000;
        step();
        bus.i_dunit_we = 1'b0;
        bus.i_dunit_clk_en = 1'b1;
        for (int n = 0; n < 3; n++) step();
        check("pre_halt_pc", bus.o_pc, 32'hC);
        check("pre_halt",    32'(bus.o_halt), 32'h0);
        step();
        check("halt_flag", 32'(bus.o_halt), 32'h1);
        check("halt_inst", bus.o_inst,    32'hFFFF_FFFF);
        check("halt_pcp4", bus.o_pcplus4, 32'h10);
        check("halt_pc",   bus.o_pc,      32'hC);
        for (int n = 0; n < 10; n++) begin
            bus.i_PCSrc = n[0];
            bus.i_branch_target = 32'h200;
            step();
        end
        bus.i_PCSrc = 1'b0;
        check("halt_hold_pc", bus.o_pc, 32'hC);
        check("halt_hold",    32'(bus.o_halt), 32'h1);
        rst_n = 1'b0;
        step();
        check("halt_rst_pc",   bus.o_pc,        32'h0);
        check("halt_rst_inst", bus.o_inst,      32'h0);
        check("halt_rst_pcp4", bus.o_pcplus4,   32'h0);
        check("halt_rst_halt", 32'(bus.o_halt), 32'h0);
        rst_n = 1'b1;
        step();
        check("post_rst_inst", bus.o_inst, 32'h0BAD_0000);

        if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
